// File: rtl/sprite_rom_pkg.sv
// sprite_pkg: shared types and width helpers for the sprite ROM.
//   sprite_req_t : one draw request (x, y, frame, flip, tag) at carrier width
//   sprite_px_t  : one ROM result (palette index, transparent flag, tag)
// Carrier fields are sized for the widest supported configuration.
// Each user zero-extends into them and slices back out at the block's own widths.
package sprite_pkg;

  localparam int SPR_CW = 16;  // coordinate / frame carrier width
  localparam int SPR_IW = 8;   // palette index carrier width
  localparam int SPR_TW = 32;  // tag carrier width

  typedef struct packed {
    logic [SPR_CW-1:0] x;
    logic [SPR_CW-1:0] y;
    logic [SPR_CW-1:0] frame;
    logic              flip;
    logic [SPR_TW-1:0] tag;
  } sprite_req_t;

  typedef struct packed {
    logic [SPR_IW-1:0] index;
    logic              transparent;
    logic [SPR_TW-1:0] tag;
  } sprite_px_t;

  // ROM address width for w*h*f words (at least 1 bit).
  function automatic int sprite_aw(int w, int h, int f);
    int d;
    d = w * h * f;
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

  // Frame port width: max(1, clog2(f)) plus one bit for out-of-range values.
  function automatic int sprite_fw(int f);
    return ((f <= 2) ? 1 : $clog2(f)) + 1;
  endfunction

endpackage

// File: rtl/sprite_rom_if.sv
// sprite_rom_if: request/result handshake bundle for sprite_rom.
//   master : draw logic side (drives in_*, out_ready)
//   slave  : sprite_rom side (drives in_ready, out_*)
// Optional: SPRITE_ROM_FLIP_EN adds in_flip_h.
interface sprite_rom_if #(
  parameter int XW     = 6,
  parameter int YW     = 6,
  parameter int FW     = 2,
  parameter int CDEPTH = 3,
  parameter int TAG_W  = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [XW-1:0]     in_x;
  logic [YW-1:0]     in_y;
  logic [FW-1:0]     in_frame;
`ifdef SPRITE_ROM_FLIP_EN
  logic              in_flip_h;
`endif
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [CDEPTH-1:0] out_index;
  logic              out_transparent;
  logic [TAG_W-1:0]  out_tag;

  modport master (
`ifdef SPRITE_ROM_FLIP_EN
    output in_flip_h,
`endif
    output in_valid, in_x, in_y, in_frame, in_tag, out_ready,
    input  in_ready, out_valid, out_index, out_transparent, out_tag
  );

  modport slave (
`ifdef SPRITE_ROM_FLIP_EN
    input  in_flip_h,
`endif
    input  in_valid, in_x, in_y, in_frame, in_tag, out_ready,
    output in_ready, out_valid, out_index, out_transparent, out_tag
  );
endinterface

// File: rtl/sprite_rom_mem.sv
// sprite_mem: registered-read ROM. Contents are loaded from INIT_FILE at configuration.
// They are never reset.
//   clk_i   : clock
//   re_i    : read enable; rdata_o holds its value while low
//   addr_i  : word address
//   rdata_o : registered read data
module sprite_mem #(
  parameter int    DEPTH     = 1024,
  parameter int    DW        = 3,
  parameter int    AW        = 10,
  parameter string INIT_FILE = "sprite.mif"
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] rdata_o
);
  (* ram_init_file = INIT_FILE *) logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i)
    if (re_i) rdata_o <= mem[addr_i];
endmodule

// File: rtl/sprite_rom.sv
// sprite_rom: two-stage pipelined sprite bitmap ROM.
// The block does a bounds check on every request, flags transparent pixels and supports output backpressure.
//   clock   : rising-edge clock
//   reset_n : async active-low reset (ROM contents unaffected)
//   bus     : sprite_rom_if.slave (in_* request, out_* result, valid/ready)
// Stage S1 registers the address, oob flag and tag.
// Stage S2 registers the ROM word, oob flag and tag, and drives the outputs.
// Optional: SPRITE_ROM_FLIP_EN enables the in_flip_h horizontal mirror.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int    WIDTH      = 32,
  parameter int    HEIGHT     = 32,
  parameter int    FRAMES     = 1,
  parameter int    CDEPTH     = 3,
  parameter int    TRANSP_IDX = 0,
  parameter int    TAG_W      = 10,
  parameter string INIT_FILE  = "sprite.mif"
) (
  input logic         clock,
  input logic         reset_n,
  sprite_rom_if.slave bus
);
  localparam int STAGES = 2;
  localparam int DEPTH  = WIDTH * HEIGHT * FRAMES;
  localparam int AW     = sprite_aw(WIDTH, HEIGHT, FRAMES);

  sprite_req_t         req;
  sprite_px_t          px;
  logic                adv;
  logic                oob_d;
  logic [31:0]         col_d;
  logic [AW-1:0]       addr_d;
  logic [STAGES:1]     vld_pipe_q;
  logic [AW-1:0]       s1_addr_q;
  logic                s1_oob_q;
  logic [SPR_TW-1:0]   s1_tag_q;
  logic                s2_oob_q;
  logic [SPR_TW-1:0]   s2_tag_q;
  logic [CDEPTH-1:0]   rom_q;
  logic                unused_bits;

  // Everything moves together; a held result freezes the whole pipe.
  assign adv          = !vld_pipe_q[STAGES] || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    req       = '0;
    req.x     = SPR_CW'(bus.in_x);
    req.y     = SPR_CW'(bus.in_y);
    req.frame = SPR_CW'(bus.in_frame);
    req.tag   = SPR_TW'(bus.in_tag);
`ifdef SPRITE_ROM_FLIP_EN
    req.flip  = bus.in_flip_h;
`endif
  end

  // S1: bounds check first, then optional mirror, then linear address.
  // Product terms are 32-bit so nothing truncates before the final AW cut.
  always_comb begin
    oob_d = (32'(req.x) >= 32'(WIDTH)) || (32'(req.y) >= 32'(HEIGHT)) ||
            (32'(req.frame) >= 32'(FRAMES));
    col_d = 32'(req.x);
    if (req.flip && (32'(req.x) < 32'(WIDTH)))
      col_d = 32'(WIDTH - 1) - 32'(req.x);
    addr_d = oob_d ? '0 :
             AW'(32'(req.frame) * 32'(WIDTH * HEIGHT) + 32'(req.y) * 32'(WIDTH) + col_d);
  end

  // oob regs reset to 1 so the idle outputs read index 0 / transparent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      s1_addr_q  <= '0;
      s1_oob_q   <= 1'b1;
      s1_tag_q   <= '0;
      s2_oob_q   <= 1'b1;
      s2_tag_q   <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
      s1_addr_q  <= addr_d;
      s1_oob_q   <= oob_d;
      s1_tag_q   <= req.tag;
      s2_oob_q   <= s1_oob_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  // S2 ROM word, read in lockstep with the S2 flag/tag registers.
  sprite_mem #(
    .DEPTH    (DEPTH),
    .DW       (CDEPTH),
    .AW       (AW),
    .INIT_FILE(INIT_FILE)
  ) u_mem (
    .clk_i  (clock),
    .re_i   (adv),
    .addr_i (s1_addr_q),
    .rdata_o(rom_q)
  );

  always_comb begin
    px             = '0;
    px.index       = s2_oob_q ? '0 : SPR_IW'(rom_q);
    px.transparent = s2_oob_q || (rom_q == CDEPTH'(TRANSP_IDX));
    px.tag         = s2_tag_q;
  end

  assign bus.out_valid       = vld_pipe_q[STAGES];
  assign bus.out_index       = px.index[CDEPTH-1:0];
  assign bus.out_transparent = px.transparent;
  assign bus.out_tag         = px.tag[TAG_W-1:0];

  // Carrier bits beyond this configuration's widths.
  assign unused_bits = ^{px, req.flip};
endmodule
